cellram_responder: RTL

Synchronous-burst CellularRAM device-side responder: the memory end of the cellram bus. It decodes ADV/CE/WE/OE/CRE/LB/UB, latches addresses and accepts configuration register writes (RCR/BCR). It serves fixed-latency burst reads and writes from an internal word array, driving WAIT and the data bus. It is used as the synthesizable stand-in memory for bring-up and self-test of the cellram controller path.

---
 rtl/cellram_responder.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/cellram_responder.sv
// Device-side CellularRAM responder: decodes the control pins, serves fixed-latency
// bursts from an internal word array and holds the BCR/RCR configuration registers.
module cellram_responder #(
    parameter int          Nb         = 16,
    parameter int          Nb_addr    = 23,
    parameter int          row_bits   = 7,
    parameter int          depth_bits = 10,
    parameter int          latency    = 3,
    parameter logic [15:0] bcr_reset  = 16'h9D1F,
    parameter logic [15:0] rcr_reset  = 16'h0010
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               mem_adv_n,
    input  logic               mem_ce_n,
    input  logic               mem_oe_n,
    input  logic               mem_we_n,
    input  logic               mem_cre,
    input  logic               mem_lb_n,
    input  logic               mem_ub_n,
    input  logic [Nb_addr-1:0] mem_a,
    input  logic [Nb-1:0]      mem_dq_in,
    output logic [Nb-1:0]      mem_dq_out,
    output logic               mem_dq_oe,
    output logic               mem_wait,
    output logic [15:0]        bcr,
    output logic [15:0]        rcr
);

    // state     | meaning
    // S_IDLE    | no access in progress
    // S_CFG     | config register access, commit on ce_n rising
    // S_LATENCY | WAIT asserted, counting down initial latency
    // S_READ    | read burst, one word per transfer edge
    // S_WRITE   | write burst, one word per transfer edge
    // S_ROW_END | burst crossed the row boundary, stalled until ce_n high
    typedef enum logic [2:0] {
        S_IDLE, S_CFG, S_LATENCY, S_READ, S_WRITE, S_ROW_END
    } state_t;

    localparam logic [3:0] LAT_INIT = 4'(latency - 1);

    state_t               state_q, state_d;
    logic [Nb_addr-1:0]   cur_addr_q, cur_addr_d;
    logic                 acc_we_n_q, acc_we_n_d;
    logic                 cfg_pend_q, cfg_pend_d;
    logic [3:0]           lat_cnt_q, lat_cnt_d;
    logic                 wait_q, wait_d;
    logic [Nb-1:0]        dq_out_q, dq_out_d;
    logic [15:0]          bcr_q, bcr_d;
    logic [15:0]          rcr_q, rcr_d;
    logic [Nb-1:0]        ram_q [2**depth_bits];

    logic                 latch_edge;
    logic                 xfer;
    logic                 row_last;
    logic                 wr_lo;
    logic                 wr_hi;
    logic [Nb_addr-1:0]   next_addr;
    logic [depth_bits-1:0] cur_idx;
    logic [depth_bits-1:0] next_idx;

    assign latch_edge = !mem_ce_n && !mem_adv_n;
    assign xfer       = !mem_ce_n && mem_adv_n && !wait_q
                        && (state_q == S_READ || state_q == S_WRITE);
    assign row_last   = &cur_addr_q[row_bits-1:0];
    assign next_addr  = cur_addr_q + Nb_addr'(1);
    assign cur_idx    = cur_addr_q[depth_bits-1:0];
    assign next_idx   = next_addr[depth_bits-1:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= S_IDLE;
            cur_addr_q <= '0;
            acc_we_n_q <= 1'b1;
            cfg_pend_q <= 1'b0;
            lat_cnt_q  <= '0;
            wait_q     <= 1'b0;
            dq_out_q   <= '0;
            bcr_q      <= bcr_reset;
            rcr_q      <= rcr_reset;
        end else begin
            state_q    <= state_d;
            cur_addr_q <= cur_addr_d;
            acc_we_n_q <= acc_we_n_d;
            cfg_pend_q <= cfg_pend_d;
            lat_cnt_q  <= lat_cnt_d;
            wait_q     <= wait_d;
            dq_out_q   <= dq_out_d;
            bcr_q      <= bcr_d;
            rcr_q      <= rcr_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (latch_edge) begin
            state_d = mem_cre ? S_CFG : S_LATENCY;
        end else begin
            case (state_q)
                S_CFG: begin
                    if (mem_ce_n) state_d = S_IDLE;
                end
                S_LATENCY: begin
                    if (mem_ce_n)              state_d = S_IDLE;
                    else if (lat_cnt_q == '0)  state_d = acc_we_n_q ? S_READ : S_WRITE;
                end
                S_READ, S_WRITE: begin
                    if (mem_ce_n)              state_d = S_IDLE;
                    else if (xfer && row_last) state_d = S_ROW_END;
                end
                S_ROW_END: begin
                    if (mem_ce_n) state_d = S_IDLE;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        cur_addr_d = cur_addr_q;
        acc_we_n_d = acc_we_n_q;
        cfg_pend_d = cfg_pend_q;
        lat_cnt_d  = lat_cnt_q;
        wait_d     = wait_q;
        dq_out_d   = dq_out_q;
        bcr_d      = bcr_q;
        rcr_d      = rcr_q;
        wr_lo      = 1'b0;
        wr_hi      = 1'b0;
        if (latch_edge) begin
            cur_addr_d = mem_a;
            acc_we_n_d = mem_we_n;
            cfg_pend_d = !mem_we_n;
            lat_cnt_d  = LAT_INIT;
            wait_d     = !mem_cre;
        end else begin
            case (state_q)
                S_CFG: begin
                    if (mem_ce_n) begin
                        if (cfg_pend_q) begin
                            if (cur_addr_q[19:18] == 2'b00)      rcr_d = cur_addr_q[15:0];
                            else if (cur_addr_q[19:18] == 2'b10) bcr_d = cur_addr_q[15:0];
                        end
                        cfg_pend_d = 1'b0;
                    end else if (!mem_we_n) begin
                        cfg_pend_d = 1'b1;
                    end
                end
                S_LATENCY: begin
                    if (mem_ce_n) begin
                        wait_d = 1'b0;
                    end else if (lat_cnt_q == '0) begin
                        wait_d = 1'b0;
                        if (acc_we_n_q) dq_out_d = ram_q[cur_idx];
                    end else begin
                        lat_cnt_d = lat_cnt_q - 4'd1;
                    end
                end
                S_READ, S_WRITE: begin
                    if (mem_ce_n) begin
                        wait_d = 1'b0;
                    end else if (xfer) begin
                        cur_addr_d = next_addr;
                        if (state_q == S_READ) begin
                            dq_out_d = ram_q[next_idx];
                        end else if (!mem_we_n) begin
                            wr_lo = !mem_lb_n;
                            wr_hi = !mem_ub_n;
                        end
                        // the last word of a row still transfers; WAIT stalls afterwards
                        if (row_last) wait_d = 1'b1;
                    end
                end
                S_ROW_END: begin
                    if (mem_ce_n) wait_d = 1'b0;
                end
                default: wait_d = 1'b0;
            endcase
        end
    end

    // array contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            if (wr_lo) ram_q[cur_idx][7:0]    <= mem_dq_in[7:0];
            if (wr_hi) ram_q[cur_idx][Nb-1:8] <= mem_dq_in[Nb-1:8];
        end
    end

    assign mem_dq_out = dq_out_q;
    assign mem_dq_oe  = (state_q == S_READ) && !mem_oe_n && !mem_ce_n;
    assign mem_wait   = wait_q;
    assign bcr        = bcr_q;
    assign rcr        = rcr_q;

endmodule
